// File: rtl/text_overlay_multi.sv
// -----------------------------------------------------------------------------
// text_overlay_multi
//
// Multi-window text overlay stage for the VGA pixel pipeline. Up to NUM_BOXES
// character windows (8x16 px glyph cells, COLS x ROWS characters each) are
// composited over the incoming pixel stream in one three-stage pass. Window
// position, colour, enable (and blink request) are shadowed on the rising edge
// of vblnk_in so that mid-frame edits never tear the picture. Window 0 has the
// highest priority; overlapped windows are hidden underneath it.
//
// One external char-code lookup (combinational) and one synchronous font ROM
// (1 pclk latency) are shared by all windows.
//
// Optional feature: define TEXT_OVERLAY_BLINK_EN to build a 6-bit frame
// counter; window i is then suppressed while box_blink[i] (shadowed) and
// frame_cnt[BLINK_BIT] are both set. Undefined: box_blink is ignored.
//
// Ports
//   pclk, rst                   pixel clock, asynchronous active-low reset
//   hcount_in .. vblnk_in       input video timing
//   rgb_in                      background pixel
//   box_en/x/y/color/blink      per-window configuration (box i in slice i)
//   char_box, char_xy           char lookup request {row,col} for the window hit
//   char_code                   char code returned combinationally
//   font_addr                   {char_code, glyph line} to the font ROM
//   font_pixels                 font ROM row, bit 7 = leftmost pixel
//   hcount_out .. vblnk_out     timing delayed by 3 pclk
//   rgb_out                     composited pixel delayed by 3 pclk
// -----------------------------------------------------------------------------
module text_overlay_multi #(
    parameter  int NUM_BOXES = 4,
    parameter  int COLS      = 16,
    parameter  int ROWS      = 16,
    parameter  int BLINK_BIT = 5,
    localparam int ID_W      = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
    input  logic                      pclk,
    input  logic                      rst,
    input  logic [10:0]               hcount_in,
    input  logic [10:0]               vcount_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      hblnk_in,
    input  logic                      vblnk_in,
    input  logic [11:0]               rgb_in,
    input  logic [NUM_BOXES-1:0]      box_en,
    input  logic [11*NUM_BOXES-1:0]   box_x,
    input  logic [11*NUM_BOXES-1:0]   box_y,
    input  logic [12*NUM_BOXES-1:0]   box_color,
    input  logic [NUM_BOXES-1:0]      box_blink,
    output logic [ID_W-1:0]           char_box,
    output logic [7:0]                char_xy,
    input  logic [6:0]                char_code,
    output logic [10:0]               font_addr,
    input  logic [7:0]                font_pixels,
    output logic [10:0]               hcount_out,
    output logic [10:0]               vcount_out,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      hblnk_out,
    output logic                      vblnk_out,
    output logic [11:0]               rgb_out
);

    localparam logic [11:0] WIN_W = 12'(8 * COLS);
    localparam logic [11:0] WIN_H = 12'(16 * ROWS);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } timing_t;

    typedef struct packed {
        logic            hit;
        logic [ID_W-1:0] id;
        logic [3:0]      row;
        logic [3:0]      col;
        logic [3:0]      line;
        logic [2:0]      px_bit;
        logic [11:0]     colour;
        timing_t         tim;
        logic [11:0]     rgb;
    } s1_t;

    typedef struct packed {
        logic        hit;
        logic [2:0]  px_bit;
        logic [11:0] colour;
        timing_t     tim;
        logic [11:0] rgb;
    } s2_t;

    // ---------------------------------------------------------------- shadow
    logic                    vblnk_prev_q;
    logic                    vblank_rise;
    logic [NUM_BOXES-1:0]    sh_en_q;
    logic [11*NUM_BOXES-1:0] sh_x_q;
    logic [11*NUM_BOXES-1:0] sh_y_q;
    logic [12*NUM_BOXES-1:0] sh_color_q;
    logic [NUM_BOXES-1:0]    blink_mask;

    assign vblank_rise = vblnk_in & ~vblnk_prev_q;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            vblnk_prev_q <= 1'b0;
            sh_en_q      <= '0;
            sh_x_q       <= '0;
            sh_y_q       <= '0;
            sh_color_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            vblnk_prev_q <= vblnk_in;
            if (vblank_rise) begin
                sh_en_q    <= box_en;
                sh_x_q     <= box_x;
                sh_y_q     <= box_y;
                sh_color_q <= box_color;
            end
        end
    end

`ifdef TEXT_OVERLAY_BLINK_EN
    logic [NUM_BOXES-1:0] sh_blink_q;
    logic [5:0]           frame_cnt_q;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            sh_blink_q  <= '0;
            frame_cnt_q <= '0;
        end else if (vblank_rise) begin
            sh_blink_q  <= box_blink;
            frame_cnt_q <= frame_cnt_q + 6'd1;
        end
    end

    assign blink_mask = sh_blink_q & {NUM_BOXES{frame_cnt_q[BLINK_BIT]}};
`else
    logic blink_unused;
    assign blink_unused = ^box_blink;
    assign blink_mask   = '0;
`endif

    // ------------------------------------------------------ hit detection
    // rel < W together with pos >= origin is the 12-bit "pos < origin + W"
    // test: the subtraction never wraps, so a window running past 2047 is
    // clipped instead of reappearing at the left/top edge.
    logic [11:0]          rel_x [NUM_BOXES];
    logic [11:0]          rel_y [NUM_BOXES];
    logic [NUM_BOXES-1:0] hit;

    always_comb begin
        for (int i = 0; i < NUM_BOXES; i++) begin
            rel_x[i] = {1'b0, hcount_in} - {1'b0, sh_x_q[11*i +: 11]};
            rel_y[i] = {1'b0, vcount_in} - {1'b0, sh_y_q[11*i +: 11]};
            hit[i]   = sh_en_q[i] & ~blink_mask[i] & ~hblnk_in & ~vblnk_in
                     & (hcount_in >= sh_x_q[11*i +: 11]) & (rel_x[i] < WIN_W)
                     & (vcount_in >= sh_y_q[11*i +: 11]) & (rel_y[i] < WIN_H);
        end
    end

    // ------------------------------------------------ stage 1 next state
    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    timing_t     tim_out_q;
    logic [11:0] rgb_d, rgb_out_q;

    always_comb begin
        // NOTE: default everything first so no path leaves a value held,
        // which would infer a latch.
        s1_d = '0;
        // Descending scan: the lowest-index hit is written last and wins.
        for (int i = NUM_BOXES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                s1_d.hit    = 1'b1;
                s1_d.id     = ID_W'(i);
                s1_d.col    = rel_x[i][6:3];
                s1_d.px_bit = rel_x[i][2:0];
                s1_d.row    = rel_y[i][7:4];
                s1_d.line   = rel_y[i][3:0];
                s1_d.colour = sh_color_q[12*i +: 12];
            end
        end
        s1_d.tim.hcount = hcount_in;
        s1_d.tim.vcount = vcount_in;
        s1_d.tim.hsync  = hsync_in;
        s1_d.tim.vsync  = vsync_in;
        s1_d.tim.hblnk  = hblnk_in;
        s1_d.tim.vblnk  = vblnk_in;
        s1_d.rgb        = rgb_in;
    end

    always_comb begin
        s2_d.hit    = s1_q.hit;
        s2_d.px_bit = s1_q.px_bit;
        s2_d.colour = s1_q.colour;
        s2_d.tim    = s1_q.tim;
        s2_d.rgb    = s1_q.rgb;
    end

    // font_pixels belongs to the pixel now in stage 2.
    always_comb begin
        rgb_d = (s2_q.hit & font_pixels[3'd7 - s2_q.px_bit]) ? s2_q.colour : s2_q.rgb;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            tim_out_q <= '0;
            rgb_out_q <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            tim_out_q <= s2_q.tim;
            rgb_out_q <= rgb_d;
        end
    end

    // ------------------------------------------------------------ outputs
    assign char_box   = s1_q.id;
    assign char_xy    = {s1_q.row, s1_q.col};
    assign font_addr  = {char_code, s1_q.line};
    assign hcount_out = tim_out_q.hcount;
    assign vcount_out = tim_out_q.vcount;
    assign hsync_out  = tim_out_q.hsync;
    assign vsync_out  = tim_out_q.vsync;
    assign hblnk_out  = tim_out_q.hblnk;
    assign vblnk_out  = tim_out_q.vblnk;
    assign rgb_out    = rgb_out_q;

endmodule

// File: tb/tb_text_overlay_multi.sv
// -----------------------------------------------------------------------------
// tb_text_overlay_multi
//
// Randomised pixel stream against a behavioural window model. The driver
// pushes expected char lookups and expected output pixels into queues; a
// monitor on the falling edge pops and compares them when they are due.
// -----------------------------------------------------------------------------
module tb_text_overlay_multi;

    localparam int NB   = 4;
    localparam int COLS = 16;
    localparam int ROWS = 16;
    localparam int BB   = 0;

    logic              pclk = 1'b0;
    logic              rst  = 1'b0;
    logic [10:0]       hcount_in = '0, vcount_in = '0;
    logic              hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0]       rgb_in = '0;
    logic [NB-1:0]     box_en = '0, box_blink = '0;
    logic [11*NB-1:0]  box_x = '0, box_y = '0;
    logic [12*NB-1:0]  box_color = '0;
    logic [1:0]        char_box;
    logic [7:0]        char_xy;
    logic [6:0]        char_code;
    logic [10:0]       font_addr;
    logic [7:0]        font_pixels = '0;
    logic [10:0]       hcount_out, vcount_out;
    logic              hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0]       rgb_out;

    text_overlay_multi #(
        .NUM_BOXES(NB), .COLS(COLS), .ROWS(ROWS), .BLINK_BIT(BB)
    ) dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .box_en(box_en), .box_x(box_x), .box_y(box_y),
        .box_color(box_color), .box_blink(box_blink),
        .char_box(char_box), .char_xy(char_xy), .char_code(char_code),
        .font_addr(font_addr), .font_pixels(font_pixels),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 pclk = ~pclk;

    int unsigned cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // ------------------------------------------------ environment stubs
    // Char lookup: box 0, cell 0 returns 'A' (65).
    function automatic logic [6:0] code_fn(input logic [1:0] box, input logic [7:0] xy);
        int v;
        v = int'(xy) * 5 + int'(box) * 23 + 65;
        return 7'(v % 128);
    endfunction

    function automatic logic [7:0] font_fn(input logic [10:0] a);
        int v;
        v = int'(a);
        return 8'((v * 157) ^ (v >> 3));
    endfunction

    assign char_code = code_fn(char_box, char_xy);
    always @(posedge pclk) font_pixels <= font_fn(font_addr);

    // ------------------------------------------------------- scoreboard
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int unsigned chk;
        int          hc, vc;
        logic [25:0] tim;
        logic [11:0] rgb;
    } pix_exp_t;

    typedef struct {
        int unsigned chk;
        logic [1:0]  box;
        logic [7:0]  xy;
    } chr_exp_t;

    pix_exp_t pq[$];
    chr_exp_t cq[$];

    always @(negedge pclk) begin
        chr_exp_t ce;
        pix_exp_t pe;
        if (rst) begin
            while (cq.size() > 0 && cq[0].chk <= cyc) begin
                ce = cq.pop_front();
                if (ce.chk == cyc)
                    check("char_lookup", {char_box, char_xy}, {ce.box, ce.xy});
                else begin
                    n_checks++; n_fail++;
                    $display("FAIL char_lookup: entry due at cycle %0d missed", ce.chk);
                end
            end
            while (pq.size() > 0 && pq[0].chk <= cyc) begin
                pe = pq.pop_front();
                if (pe.chk == cyc) begin
                    check($sformatf("timing(%0d,%0d)", pe.hc, pe.vc),
                          {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, pe.tim);
                    check($sformatf("rgb(%0d,%0d)", pe.hc, pe.vc), rgb_out, pe.rgb);
                end else begin
                    n_checks++; n_fail++;
                    $display("FAIL pixel: entry due at cycle %0d missed", pe.chk);
                end
            end
        end
    end

    // ------------------------------------------------- reference model
    int   sh_en [NB], sh_x [NB], sh_y [NB], sh_blink [NB];
    logic [11:0] sh_col [NB];
    bit   model_prev_vb = 1'b0;
    int   frame_cnt = 0;

    function automatic bit covers(input int i, input int hc, input int vc);
        bit supp;
        supp = 1'b0;
`ifdef TEXT_OVERLAY_BLINK_EN
        supp = (sh_blink[i] != 0) && (((frame_cnt % 64) >> BB) & 1) != 0;
`endif
        return (sh_en[i] != 0) && !supp &&
               hc >= sh_x[i] && hc < sh_x[i] + 8 * COLS &&
               vc >= sh_y[i] && vc < sh_y[i] + 16 * ROWS;
    endfunction

    // Drive one pixel (called just after a rising edge) and queue its results.
    task automatic step(input int hc, input int vc, input bit hb, input bit vb,
                        input bit hs, input bit vs, input logic [11:0] rgb);
        pix_exp_t pe;
        chr_exp_t ce;
        int       win, relx, rely;
        logic [7:0] pix;
        hcount_in = 11'(hc); vcount_in = 11'(vc);
        hblnk_in = hb; vblnk_in = vb; hsync_in = hs; vsync_in = vs;
        rgb_in = rgb;

        win = -1;
        if (!hb && !vb)
            for (int i = NB - 1; i >= 0; i--)
                if (covers(i, hc, vc)) win = i;

        ce.chk = cyc + 1; ce.box = '0; ce.xy = '0;
        pe.chk = cyc + 3; pe.hc = hc; pe.vc = vc;
        pe.tim = {11'(hc), 11'(vc), hs, vs, hb, vb};
        pe.rgb = rgb;
        if (win >= 0) begin
            relx   = hc - sh_x[win];
            rely   = vc - sh_y[win];
            ce.box = 2'(win);
            ce.xy  = 8'((rely / 16) * 16 + relx / 8);
            pix    = font_fn({code_fn(ce.box, ce.xy), 4'(rely % 16)});
            if (pix[7 - relx % 8]) pe.rgb = sh_col[win];
        end
        cq.push_back(ce);
        pq.push_back(pe);

        if (vb && !model_prev_vb) begin
            for (int i = 0; i < NB; i++) begin
                sh_en[i]    = int'(box_en[i]);
                sh_x[i]     = int'(box_x[11*i +: 11]);
                sh_y[i]     = int'(box_y[11*i +: 11]);
                sh_col[i]   = box_color[12*i +: 12];
                sh_blink[i] = int'(box_blink[i]);
            end
            frame_cnt++;
        end
        model_prev_vb = vb;
        @(posedge pclk); #1;
    endtask

    task automatic px(input int hc, input int vc);
        step(hc, vc, 1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom));
    endtask

    task automatic rand_pixels(input int n, input int xlo, input int xw, input int ylo, input int yh);
        for (int k = 0; k < n; k++)
            step(xlo + int'($urandom_range(xw - 1, 0)), ylo + int'($urandom_range(yh - 1, 0)),
                 ($urandom_range(15, 0) == 0), 1'b0,
                 1'($urandom), 1'($urandom), 12'($urandom));
    endtask

    task automatic vblank(input int n);
        for (int k = 0; k < n; k++)
            step(int'($urandom_range(1000, 0)), 600 + k, 1'b1, 1'b1, 1'b0, 1'b1, 12'($urandom));
    endtask

    // Asynchronous reset for n cycles; outputs must be zero throughout.
    task automatic do_reset(input int n);
        rst = 1'b0;
        cq.delete();
        pq.delete();
        for (int i = 0; i < NB; i++) begin
            sh_en[i] = 0; sh_x[i] = 0; sh_y[i] = 0; sh_blink[i] = 0; sh_col[i] = '0;
        end
        model_prev_vb = 1'b0;
        frame_cnt     = 0;
        for (int k = 0; k < n; k++) begin
            hcount_in = 11'($urandom); vcount_in = 11'($urandom % 500);
            hsync_in = 1'($urandom); vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
            rgb_in = 12'($urandom);
            @(negedge pclk);
            check("reset_rgb", rgb_out, 12'h000);
            check("reset_timing", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 26'h0);
            check("reset_char", {char_box, char_xy}, 10'h0);
            @(posedge pclk); #1;
        end
        rst = 1'b1;
    endtask

    // --------------------------------------------------------- stimulus
    initial begin
        @(posedge pclk); #1;
        do_reset(5);

        // Configuration for the first frame; not visible until vblank.
        box_en    = 4'b1111;
        box_x     = {11'd0, 11'd2040, 11'd150, 11'd100};
        box_y     = {11'd0, 11'd0,    11'd150, 11'd50};
        box_color = {12'h0FF, 12'h00F, 12'h0F0, 12'hFFF};
        box_blink = '0;
        for (int h = 100; h < 108; h++) px(h, 50);
        rand_pixels(60, 0, 400, 0, 400);
        vblank(4);

        // Frame 1: single window, clip, priority.
        for (int h = 100; h < 108; h++) px(h, 50);
        for (int h = 100; h < 108; h++) px(h, 51);
        px(0, 0); px(127, 0); px(128, 0);
        px(200, 200);
        rand_pixels(300, 0, 512, 0, 512);
        rand_pixels(40, 2030, 18, 0, 300);

        // Mid-frame edit: rest of this frame keeps the old geometry.
        box_x[10:0]     = 11'd180;
        box_color[11:0] = 12'hF00;
        rand_pixels(200, 80, 240, 40, 300);
        vblank(4);

        // Frame 2: box 0 at 180 overlaps box 1 around (200,200).
        for (int h = 200; h < 216; h++) px(h, 200);
        rand_pixels(300, 140, 200, 140, 300);

        // Reset mid-frame; afterwards nothing is drawn until the next vblank.
        do_reset(5);
        rand_pixels(100, 0, 400, 0, 400);

        // Blink requests on every window.
        box_blink = 4'b1111;
        repeat (4) begin
            vblank(3);
            rand_pixels(200, 0, 400, 0, 400);
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && (pq.size() > 0 || cq.size() > 0); k++)
            @(posedge pclk);
        @(negedge pclk);
        if (pq.size() > 0 || cq.size() > 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain: %0d pixel and %0d char entries still pending", pq.size(), cq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
